// File: rtl/pe_os_pkg.sv
// pe_os_pkg: shared state encoding and saturation helpers for pe_os_vec.
// The saturation helpers are only referenced when PE_SAT_EN is defined.
package pe_os_pkg;

    localparam int STATE_W = 2;
    localparam int SAT_W   = 128;

    typedef enum logic [STATE_W-1:0] {
        IDLE      = 2'd0,
        ACCUM     = 2'd1,
        DRAIN_OWN = 2'd2,
        PASS      = 2'd3
    } state_t;

    // Largest representable accumulator value for a width and signedness.
    function automatic logic [SAT_W-1:0] sat_hi(input int w, input bit sgn);
        logic [SAT_W-1:0] one;
        one = SAT_W'(1);
        return sgn ? (one << (w - 1)) - one : (one << w) - one;
    endfunction

    // Smallest representable accumulator value, two's complement in SAT_W bits.
    function automatic logic [SAT_W-1:0] sat_lo(input int w, input bit sgn);
        logic [SAT_W-1:0] one;
        one = SAT_W'(1);
        return sgn ? ~((one << (w - 1)) - one) : '0;
    endfunction

endpackage

// File: rtl/pe_mac_lane.sv
// pe_mac_lane: one output channel's multiply, extend, zero gate and accumulate.
// PE_SAT_EN selects clamping accumulation; otherwise sums wrap.
module pe_mac_lane #(
    parameter int WIDTH_A   = 16,
    parameter int WIDTH_B   = 16,
    parameter int WIDTH_MAC = 48,
    parameter int SIGNED    = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 en,
    input  logic [WIDTH_A-1:0]   act,
    input  logic [WIDTH_B-1:0]   wei,
    output logic [WIDTH_MAC-1:0] acc
);
    import pe_os_pkg::*;

    localparam int PW = WIDTH_A + WIDTH_B;

    logic [PW-1:0]        prod;
    logic [WIDTH_MAC-1:0] acc_nx;
    logic                 gate;

    generate
        if (SIGNED != 0) begin : g_sgn
            assign prod = PW'($signed(act)) * PW'($signed(wei));
        end else begin : g_uns
            assign prod = PW'(act) * PW'(wei);
        end
    endgenerate

    assign gate = en && (act != '0) && (wei != '0);

`ifdef PE_SAT_EN
    localparam int SW = ((WIDTH_MAC > PW) ? WIDTH_MAC : PW) + 1;
    localparam logic [SAT_W-1:0] HI = sat_hi(WIDTH_MAC, SIGNED != 0);
    localparam logic [SAT_W-1:0] LO = sat_lo(WIDTH_MAC, SIGNED != 0);

    logic [SW-1:0] ext_w;
    logic [SW-1:0] acc_w;
    logic [SW-1:0] sum_w;

    // Add one bit wider than either operand, then clamp into range.
    always_comb begin
        if (SIGNED != 0) begin
            ext_w = SW'($signed(prod));
            acc_w = SW'($signed(acc));
        end else begin
            ext_w = SW'(prod);
            acc_w = SW'(acc);
        end
        sum_w  = acc_w + ext_w;
        acc_nx = sum_w[WIDTH_MAC-1:0];
        if (SIGNED != 0) begin
            if ($signed(sum_w) > $signed(SW'(HI)))
                acc_nx = WIDTH_MAC'(HI);
            else if ($signed(sum_w) < $signed(SW'(LO)))
                acc_nx = WIDTH_MAC'(LO);
        end else if (sum_w > SW'(HI)) begin
            acc_nx = WIDTH_MAC'(HI);
        end
    end
`else
    // Extend the product to accumulator width and wrap on overflow.
    always_comb begin
        if (SIGNED != 0)
            acc_nx = acc + WIDTH_MAC'($signed(prod));
        else
            acc_nx = acc + WIDTH_MAC'(prod);
    end
`endif

    // Accumulator: cleared by reset or tile start, written on gated beats.
    always_ff @(posedge clk) begin
        if (rst || clr)
            acc <= '0;
        else if (gate)
            acc <= acc_nx;
    end

endmodule

// File: rtl/pe_os_vec.sv
// pe_os_vec: output-stationary PE, LANES channels sharing one activation stream.
// Define PE_SAT_EN for saturating accumulation (default: modulo wrap).
module pe_os_vec #(
    parameter int WIDTH_A   = 16,
    parameter int WIDTH_B   = 16,
    parameter int WIDTH_MAC = 48,
    parameter int LANES     = 4,
    parameter int K_W       = 16,
    parameter int SIGNED    = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [K_W-1:0]           k_len,
    input  logic [K_W-1:0]           n_pass,
    input  logic [WIDTH_A-1:0]       act_in,
    input  logic [LANES*WIDTH_B-1:0] wei_in,
    input  logic                     vld_in,
    output logic [WIDTH_A-1:0]       act_out,
    output logic [LANES*WIDTH_B-1:0] wei_out,
    output logic                     vld_out,
    input  logic [WIDTH_MAC-1:0]     psum_in,
    input  logic                     psum_in_vld,
    output logic                     psum_in_rdy,
    output logic [WIDTH_MAC-1:0]     psum_out,
    output logic                     psum_out_vld,
    input  logic                     psum_out_rdy,
    output logic                     busy,
    output logic                     done
);
    import pe_os_pkg::*;

    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(LANES - 1);

    state_t               state;
    logic [K_W-1:0]       k_reg;
    logic [K_W-1:0]       n_reg;
    logic [K_W-1:0]       cnt;
    logic [K_W-1:0]       pcnt;
    logic [K_W-1:0]       cnt_nx;
    logic [K_W-1:0]       pcnt_nx;
    logic [IDX_W-1:0]     idx;
    logic                 clr;
    logic                 en;
    logic [WIDTH_MAC-1:0] acc [LANES];

    assign clr     = (state == IDLE) && start;
    assign en      = (state == ACCUM) && vld_in;
    assign cnt_nx  = cnt + 1'b1;
    assign pcnt_nx = pcnt + 1'b1;
    assign busy    = (state != IDLE);

    generate
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            pe_mac_lane #(
                .WIDTH_A  (WIDTH_A),
                .WIDTH_B  (WIDTH_B),
                .WIDTH_MAC(WIDTH_MAC),
                .SIGNED   (SIGNED)
            ) u_lane (
                .clk(clk),
                .rst(rst),
                .clr(clr),
                .en (en),
                .act(act_in),
                .wei(wei_in[l*WIDTH_B +: WIDTH_B]),
                .acc(acc[l])
            );
        end
    endgenerate

    // Operand forwarding to the neighbouring PE; never stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            act_out <= '0;
            wei_out <= '0;
            vld_out <= 1'b0;
        end else begin
            act_out <= act_in;
            wei_out <= wei_in;
            vld_out <= vld_in;
        end
    end

    // Tile sequencing: accumulate K beats, drain own lanes, then pass upstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            k_reg <= '0;
            n_reg <= '0;
            cnt   <= '0;
            pcnt  <= '0;
            idx   <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        k_reg <= k_len;
                        n_reg <= n_pass;
                        cnt   <= '0;
                        pcnt  <= '0;
                        idx   <= '0;
                        state <= (k_len != '0) ? ACCUM : DRAIN_OWN;
                    end
                end
                ACCUM: begin
                    if (vld_in) begin
                        cnt <= cnt_nx;
                        if (cnt_nx == k_reg)
                            state <= DRAIN_OWN;
                    end
                end
                DRAIN_OWN: begin
                    if (psum_out_rdy) begin
                        if (idx == LAST) begin
                            if (n_reg != '0) begin
                                state <= PASS;
                            end else begin
                                state <= IDLE;
                                done  <= 1'b1;
                            end
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                PASS: begin
                    if (psum_in_vld && psum_out_rdy) begin
                        pcnt <= pcnt_nx;
                        if (pcnt_nx == n_reg) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Partial-sum chain mux: own lanes while draining, upstream in PASS.
    always_comb begin
        psum_out     = '0;
        psum_out_vld = 1'b0;
        psum_in_rdy  = 1'b0;
        case (state)
            DRAIN_OWN: begin
                psum_out     = acc[idx];
                psum_out_vld = 1'b1;
            end
            PASS: begin
                psum_out     = psum_in;
                psum_out_vld = psum_in_vld;
                psum_in_rdy  = psum_out_rdy;
            end
            default: ;
        endcase
    end

endmodule
